adc_capture_ctrl: RTL

Capture sequencer for the SZG-ADC receive path. It replaces free-running FIFO write gating with an arm/trigger/capture/done state machine. It sits in the adc_data_clk domain between syzygy_adc_top (data, data_valid, rdy) and the capture FIFO write port. Host trigger/wire endpoints drive it, and host wire-outs read its status.

---
 rtl/adc_capture_pkg.sv | 14 +
 rtl/adc_capture_ctrl_if.sv | 23 ++
 rtl/adc_level_trigger.sv | 43 ++++
 rtl/adc_capture_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC capture sequencer: state encoding and default widths.
package adc_capture_pkg;

  localparam int unsigned DefCountWidth  = 24;
  localparam int unsigned DefSampleWidth = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Capture FIFO write port: the sequencer drives write enable and data and observes
// programmable-full.
interface adc_capture_ctrl_if #(
  parameter int unsigned SAMPLE_WIDTH = 16
);

  logic                      fifo_wr_en;
  logic [2*SAMPLE_WIDTH-1:0] fifo_din;
  logic                      fifo_prog_full;

  modport master (
    output fifo_wr_en,
    output fifo_din,
    input  fifo_prog_full
  );

  modport slave (
    input  fifo_wr_en,
    input  fifo_din,
    output fifo_prog_full
  );

endinterface

// File: rtl/adc_level_trigger.sv
// Signed rising-edge threshold detector on channel 1, active only while armed.
// The trigger output is combinational so the crossing sample itself is the first captured.
module adc_level_trigger #(
  parameter int unsigned SAMPLE_WIDTH = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           armed_i,
  input  logic                           path_ok_i,
  input  logic                           level_trig_en_i,
  input  logic signed [SAMPLE_WIDTH-1:0] threshold_i,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  output logic                           trig_o
);

  logic signed [SAMPLE_WIDTH-1:0] prev_sample_q, prev_sample_d;
  logic                           prev_valid_q, prev_valid_d;

  always_comb begin
    prev_sample_d = prev_sample_q;
    prev_valid_d  = 1'b0;
    // History only counts while armed; a fresh arm must see one good sample first.
    if (armed_i) begin
      prev_valid_d = prev_valid_q | path_ok_i;
      if (path_ok_i) begin
        prev_sample_d = sample_i;
      end
    end
    trig_o = armed_i & path_ok_i & level_trig_en_i & prev_valid_q &
             (prev_sample_q < threshold_i) & (sample_i >= threshold_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
    end else begin
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Arm/trigger/capture/done sequencer gating ADC samples into the capture FIFO.
// Runs entirely in the adc_data_clk domain with a one-cycle registered write path.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH  = DefCountWidth,
  parameter int unsigned SAMPLE_WIDTH = DefSampleWidth
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    sw_trigger,
  input  logic                    level_trig_en,
  input  logic [SAMPLE_WIDTH-1:0] threshold,
  input  logic [COUNT_WIDTH-1:0]  sample_count,
  input  logic                    mmcm_locked,
  input  logic                    idelay_rdy,
  input  logic                    data_valid,
  input  logic [SAMPLE_WIDTH-1:0] adc_data_1,
  input  logic [SAMPLE_WIDTH-1:0] adc_data_2,
  adc_capture_ctrl_if.master      fifo,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [COUNT_WIDTH-1:0]  captured,
  output logic [COUNT_WIDTH-1:0]  dropped
);

  localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  cap_state_e                state_q, state_d;
  logic [COUNT_WIDTH-1:0]    target_q, target_d;
  logic [COUNT_WIDTH-1:0]    captured_q, captured_d;
  logic [COUNT_WIDTH-1:0]    dropped_q, dropped_d;
  logic                      done_q, done_d;
  logic                      overflow_q, overflow_d;
  logic                      wr_en_q, wr_en_d;
  logic [2*SAMPLE_WIDTH-1:0] din_q, din_d;

  logic path_ok;
  logic level_trig;
  logic trig_event;
  logic cap_cycle;

  assign path_ok = mmcm_locked & idelay_rdy & data_valid;

  adc_level_trigger #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_level_trigger (
    .clk_i           (clk),
    .rst_i           (reset),
    .armed_i         (state_q == StArmed),
    .path_ok_i       (path_ok),
    .level_trig_en_i (level_trig_en),
    .threshold_i     (threshold),
    .sample_i        (adc_data_1),
    .trig_o          (level_trig)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    captured_d = captured_q;
    dropped_d  = dropped_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    din_d      = din_q;

    trig_event = (state_q == StArmed) & path_ok & (sw_trigger | level_trig);
    // The triggering cycle is treated as the first capture cycle.
    cap_cycle  = (state_q == StCapture) | trig_event;

    unique case (state_q)
      StIdle: begin
        if (arm && !abort) begin
          target_d   = sample_count;
          captured_d = '0;
          dropped_d  = '0;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = StArmed;
        end
      end
      StArmed, StCapture: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cap_cycle) begin
          state_d = StCapture;
          if (path_ok && !fifo.fifo_prog_full) begin
            wr_en_d    = 1'b1;
            din_d      = {adc_data_1, adc_data_2};
            captured_d = captured_q + CountOne;
            if ((target_q != '0) && (captured_d == target_q)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else if (path_ok) begin
            overflow_d = 1'b1;
            if (dropped_q != CountMax) begin
              dropped_d = dropped_q + CountOne;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      target_q   <= '0;
      captured_q <= '0;
      dropped_q  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      captured_q <= captured_d;
      dropped_q  <= dropped_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
    end
  end

  assign fifo.fifo_wr_en = wr_en_q;
  assign fifo.fifo_din   = din_q;
  assign busy            = (state_q == StArmed) || (state_q == StCapture);
  assign done            = done_q;
  assign overflow        = overflow_q;
  assign captured        = captured_q;
  assign dropped         = dropped_q;

endmodule
